// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared ids, read-tag type and latency bounds for onchip_mem_arbiter
package onchip_mem_pkg;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;

    // One in-flight read: whether the slot carries a read, and who asked for it.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic bit read_latency_ok(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - Avalon-MM master-side bundle for one arbiter port
//   master modport: drives address/read/write/byteenable/writedata, receives
//                   waitrequest/readdata/readdatavalid
//   slave modport : the arbiter's view of the same signals
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with optional fixed priority
//   clk, reset_n : clock, synchronous active-low reset
//   req_i[1:0]   : request per master
//   advance_i    : allow the fairness pointer to move this cycle
//   gnt_o[1:0]   : one-hot combinational grant (zero when no request)
module rr_arbiter2
    import onchip_mem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        // On a conflict the master that did not win last time goes first;
        // with fixed priority master 0 simply always wins.
        if (req_i == 2'b11) begin
            if ((FIXED_PRIO != 0) || (last_q == MASTER_M1)) begin
                gnt_o = 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end
        if (advance_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? MASTER_M1 : MASTER_M0;
        end
    end

    // Resets to master 1 so that master 0 takes the first conflict.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= MASTER_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master arbiter for the single-port on-chip RAM
//   clk, reset_n     : clock, synchronous active-low reset
//   m0, m1           : Avalon-MM slave ports (m0 = CPU data, m1 = sample fetch)
//   mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
//   mem_clken        : RAM request side, muxed from the granted master
//   mem_readdata     : RAM read data, fanned out to both masters
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave m0,
    onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("onchip_mem_arbiter: READ_LATENCY must be 1..3");
    end

    logic    m0_req;
    logic    m1_req;
    logic [1:0] req;
    logic [1:0] gnt;
    logic    issue_read;
    rd_tag_t tag_d;
    rd_tag_t tag_out;
    rd_tag_t tag_q [READ_LATENCY];

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

    // Nothing is granted while held in reset, so the RAM sees no access.
    assign req = {m1_req, m0_req} & {2{reset_n}};

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req),
        .advance_i (reset_n),
        .gnt_o     (gnt)
    );

    assign m0.waitrequest = ~reset_n | (m0_req & ~gnt[0]);
    assign m1.waitrequest = ~reset_n | (m1_req & ~gnt[1]);

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        issue_read     = 1'b0;
        if (gnt[0]) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
            mem_write      = m0.write;
            issue_read     = m0.read & ~m0.write;
        end else if (gnt[1]) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_write      = m1.write;
            issue_read     = m1.read & ~m1.write;
        end
    end

    assign mem_chipselect = |gnt;
    assign mem_clken      = 1'b1;

    assign tag_d.valid = issue_read;
    assign tag_d.id    = gnt[1] ? MASTER_M1 : MASTER_M0;

    // One slot per cycle of RAM latency; the last slot lines up with mem_readdata.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[READ_LATENCY-1];

    // Masked by reset_n so a read caught by reset is never reported, even one
    // whose data would otherwise arrive during the reset cycle itself.
    assign m0.readdatavalid = reset_n & tag_out.valid & (tag_out.id == MASTER_M0);
    assign m1.readdatavalid = reset_n & tag_out.valid & (tag_out.id == MASTER_M1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] a0, a1;
    logic        r0, r1, wr0, wr1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;

    // Config 0: round-robin, latency 1; config 1: fixed priority; config 2: latency 2.
    logic [2:0]        w0, w1, v0, v1, cs, we, ck;
    logic [2:0][31:0]  d0, d1, mwd;
    logic [2:0][15:0]  ma;
    logic [2:0][3:0]   mbe;

    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int LAT = (k == 2) ? 2 : 1;
        localparam int FP  = (k == 1) ? 1 : 0;

        onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
        onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();

        logic [15:0] mem_address;
        logic [3:0]  mem_byteenable;
        logic        mem_chipselect, mem_write, mem_clken;
        logic [31:0] mem_writedata, mem_readdata;
        logic [31:0] ram [65536];
        logic [15:0] addr_q;
        logic [31:0] dly_q;

        assign m0_if.address = a0;  assign m0_if.read = r0;  assign m0_if.write = wr0;
        assign m0_if.byteenable = be0;  assign m0_if.writedata = wd0;
        assign m1_if.address = a1;  assign m1_if.read = r1;  assign m1_if.write = wr1;
        assign m1_if.byteenable = be1;  assign m1_if.writedata = wd1;

        onchip_mem_arbiter #(
            .ADDR_W(16), .DATA_W(32), .READ_LATENCY(LAT), .FIXED_PRIO(FP)
        ) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .m0             (m0_if),
            .m1             (m1_if),
            .mem_address    (mem_address),
            .mem_byteenable (mem_byteenable),
            .mem_chipselect (mem_chipselect),
            .mem_write      (mem_write),
            .mem_writedata  (mem_writedata),
            .mem_clken      (mem_clken),
            .mem_readdata   (mem_readdata)
        );

        // RAM: registered address, unregistered output (plus one output stage for LAT=2).
        always @(posedge clk) begin
            if (pl_en) begin
                ram[pl_addr] <= pl_data;
            end else if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            addr_q <= mem_address;
            dly_q  <= ram[addr_q];
        end
        assign mem_readdata = (LAT == 2) ? dly_q : ram[addr_q];

        assign w0[k] = m0_if.waitrequest;    assign w1[k] = m1_if.waitrequest;
        assign v0[k] = m0_if.readdatavalid;  assign v1[k] = m1_if.readdatavalid;
        assign d0[k] = m0_if.readdata;       assign d1[k] = m1_if.readdata;
        assign cs[k] = mem_chipselect;       assign we[k] = mem_write;
        assign ck[k] = mem_clken;            assign ma[k] = mem_address;
        assign mbe[k] = mem_byteenable;      assign mwd[k] = mem_writedata;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle();
        r0 = 0; wr0 = 0; r1 = 0; wr1 = 0; a0 = '0; a1 = '0;
        be0 = 4'hF; be1 = 4'hF; wd0 = '0; wd1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        pl_en = 1; pl_addr = addr; pl_data = data;
        next_cycle();
        pl_en = 0;
    endtask

    typedef struct {
        logic r0, w0, r1, w1;
        logic ew0, ew1, ecs, ewe;
        logic [15:0] eaddr;
        logic ev0, ev1;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs [8];
    int          last_w [3];
    logic [31:0] mm3 [3][64];
    exp_t        eq [3][$];
    int          cyc;

    task automatic new_req(input int m);
        int kind;
        logic rd, wr;
        kind = $urandom_range(0, 9);
        rd = (kind <= 4) || (kind == 7);
        wr = (kind >= 5) && (kind <= 7);
        if (m == 0) begin
            r0 = rd; wr0 = wr; a0 = 16'($urandom_range(0, 63)); be0 = 4'($urandom); wd0 = $urandom;
        end else begin
            r1 = rd; wr1 = wr; a1 = 16'($urandom_range(0, 63)); be1 = 4'($urandom); wd1 = $urandom;
        end
    endtask

    // Reference: grant, RAM request and read-return expectations for config k.
    task automatic model_cycle(input int k);
        int          win, lat;
        logic        ev0, ev1, rd, wr;
        logic [31:0] edata, wd;
        logic [15:0] ad;
        logic [3:0]  be;
        lat = (k == 2) ? 2 : 1;
        win = -1;
        if ((r0 | wr0) && (r1 | wr1)) win = (k == 1) ? 0 : ((last_w[k] == 0) ? 1 : 0);
        else if (r0 | wr0) win = 0;
        else if (r1 | wr1) win = 1;
        chk($sformatf("rnd%0d_w0", k), w0[k], (r0 | wr0) && win != 0);
        chk($sformatf("rnd%0d_w1", k), w1[k], (r1 | wr1) && win != 1);
        chk($sformatf("rnd%0d_cs", k), cs[k], win >= 0);
        ev0 = 0; ev1 = 0; edata = '0;
        if (eq[k].size() > 0 && eq[k][0].due == cyc) begin
            if (eq[k][0].id == 0) ev0 = 1; else ev1 = 1;
            edata = eq[k][0].data;
            void'(eq[k].pop_front());
        end
        chk($sformatf("rnd%0d_v0", k), v0[k], ev0);
        chk($sformatf("rnd%0d_v1", k), v1[k], ev1);
        if (ev0) chk($sformatf("rnd%0d_d0", k), d0[k], edata);
        if (ev1) chk($sformatf("rnd%0d_d1", k), d1[k], edata);
        if (win < 0) begin
            chk($sformatf("rnd%0d_idle_addr", k), ma[k], 0);
            chk($sformatf("rnd%0d_idle_we", k), we[k], 0);
            return;
        end
        rd = (win == 0) ? r0 : r1;   wr = (win == 0) ? wr0 : wr1;
        ad = (win == 0) ? a0 : a1;   be = (win == 0) ? be0 : be1;
        wd = (win == 0) ? wd0 : wd1;
        chk($sformatf("rnd%0d_addr", k), ma[k], ad);
        chk($sformatf("rnd%0d_we", k), we[k], wr);
        if (wr) begin
            chk($sformatf("rnd%0d_be", k), mbe[k], be);
            chk($sformatf("rnd%0d_wd", k), mwd[k], wd);
            for (int b = 0; b < 4; b++)
                if (be[b]) mm3[k][ad[5:0]][8*b +: 8] = wd[8*b +: 8];
        end else if (rd) begin
            eq[k].push_back('{due: cyc + lat, id: win, data: mm3[k][ad[5:0]]});
        end
        last_w[k] = win;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1, got0, got1;
        logic g0, g1;
        logic [31:0] x;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_w0", w0[0], 0);  chk("rst_w1", w1[0], 0);
        chk("rst_v0", v0[0], 0);  chk("rst_v1", v1[0], 0);
        chk("rst_cs", cs[0], 0);  chk("rst_we", we[0], 0);
        chk("rst_clken", ck[0], 1);
        next_cycle();

        // Table: grant / waitrequest / RAM mux / readdatavalid, round-robin config.
        vecs[0] = '{0,0,0,0, 0,0,0,0, 16'h0000, 0,0};
        vecs[1] = '{1,0,0,0, 0,0,1,0, 16'h0AAA, 0,0};
        vecs[2] = '{1,0,1,0, 1,0,1,0, 16'h0555, 1,0};
        vecs[3] = '{1,0,1,0, 0,1,1,0, 16'h0AAA, 0,1};
        vecs[4] = '{0,0,1,0, 0,0,1,0, 16'h0555, 1,0};
        vecs[5] = '{1,1,0,0, 0,0,1,1, 16'h0AAA, 0,1};
        vecs[6] = '{0,1,0,1, 1,0,1,1, 16'h0555, 0,0};
        vecs[7] = '{0,1,0,0, 0,0,1,1, 16'h0AAA, 0,0};
        for (int i = 0; i < 8; i++) begin
            r0 = vecs[i].r0; wr0 = vecs[i].w0; r1 = vecs[i].r1; wr1 = vecs[i].w1;
            a0 = 16'h0AAA; a1 = 16'h0555;
            @(negedge clk);
            chk($sformatf("vec%0d_w0", i), w0[0], vecs[i].ew0);
            chk($sformatf("vec%0d_w1", i), w1[0], vecs[i].ew1);
            chk($sformatf("vec%0d_cs", i), cs[0], vecs[i].ecs);
            chk($sformatf("vec%0d_we", i), we[0], vecs[i].ewe);
            chk($sformatf("vec%0d_addr", i), ma[0], vecs[i].eaddr);
            chk($sformatf("vec%0d_v0", i), v0[0], vecs[i].ev0);
            chk($sformatf("vec%0d_v1", i), v1[0], vecs[i].ev1);
            next_cycle();
        end
        idle();

        // Lone m0 read, latency 1.
        do_reset();
        preload(16'h0010, 32'hDEADBEEF);
        r0 = 1; a0 = 16'h0010;
        @(negedge clk); chk("t1_w0", w0[0], 0);
        next_cycle(); idle();
        @(negedge clk);
        chk("t1_v0", v0[0], 1); chk("t1_d0", d0[0], 32'hDEADBEEF); chk("t1_v1", v1[0], 0);
        next_cycle();
        @(negedge clk); chk("t1_v0_once", v0[0], 0);
        next_cycle();

        // Continuous contention: alternating grants, in-order data per master.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            preload(16'h0100 + 16'(i), 32'hC0DE_0100 + i);
            preload(16'h0200 + 16'(i), 32'hC0DE_0200 + i);
        end
        i0 = 0; i1 = 0; got0 = 0; got1 = 0;
        for (int c = 0; c < 9; c++) begin
            r0 = (i0 < 4); r1 = (i1 < 4);
            a0 = 16'h0100 + 16'(i0); a1 = 16'h0200 + 16'(i1);
            @(negedge clk);
            chk($sformatf("t2_w0_c%0d", c), w0[0], r0 && (c % 2 == 1));
            chk($sformatf("t2_w1_c%0d", c), w1[0], r1 && (c % 2 == 0));
            if (v0[0]) begin chk("t2_d0", d0[0], 32'hC0DE_0100 + got0); got0++; end
            if (v1[0]) begin chk("t2_d1", d1[0], 32'hC0DE_0200 + got1); got1++; end
            g0 = r0 & ~w0[0]; g1 = r1 & ~w1[0];
            next_cycle();
            if (g0) i0++;
            if (g1) i1++;
        end
        idle();
        chk("t2_count0", got0, 4); chk("t2_count1", got1, 4);

        // Partial write from m1, read back by m0.
        preload(16'h0300, 32'h12345678);
        wr1 = 1; a1 = 16'h0300; be1 = 4'b0011; wd1 = 32'hA5A5A5A5;
        @(negedge clk);
        chk("t3_w1", w1[0], 0); chk("t3_we", we[0], 1);
        chk("t3_addr", ma[0], 16'h0300); chk("t3_be", mbe[0], 4'b0011);
        chk("t3_wd", mwd[0], 32'hA5A5A5A5);
        next_cycle(); idle();
        r0 = 1; a0 = 16'h0300;
        next_cycle(); idle();
        @(negedge clk);
        chk("t3_v0", v0[0], 1); chk("t3_d0", d0[0], 32'h1234A5A5);
        next_cycle();

        // Fixed priority: m0 keeps winning while it requests.
        do_reset();
        r1 = 1; a1 = 16'h0500;
        for (int i = 0; i < 5; i++) begin
            r0 = 1; a0 = 16'h0510 + 16'(i);
            @(negedge clk);
            chk($sformatf("t4_w0_%0d", i), w0[1], 0);
            chk($sformatf("t4_w1_%0d", i), w1[1], 1);
            next_cycle();
        end
        r0 = 0;
        @(negedge clk);
        chk("t4_w1_last", w1[1], 0); chk("t4_addr_last", ma[1], 16'h0500);
        next_cycle(); idle();

        // Reset with a read in flight.
        do_reset();
        preload(16'h0600, 32'h600D600D);
        r0 = 1; a0 = 16'h0600;
        @(negedge clk); chk("t5_w0_issue", w0[0], 0);
        next_cycle();
        reset_n = 0; r0 = 1; r1 = 1; a0 = 16'h0610; a1 = 16'h0620;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("t5_v0_l1_%0d", i), v0[0], 0);
            chk($sformatf("t5_v1_l1_%0d", i), v1[0], 0);
            chk($sformatf("t5_v0_l2_%0d", i), v0[2], 0);
            chk($sformatf("t5_w0_%0d", i), w0[0], 1);
            chk($sformatf("t5_w1_%0d", i), w1[0], 1);
            next_cycle();
        end
        reset_n = 1;
        @(negedge clk);
        chk("t5_post_w0", w0[0], 0); chk("t5_post_w1", w1[0], 1);
        chk("t5_post_v0_l2", v0[2], 0);
        next_cycle(); idle();

        // Latency-2 build: reads m0, m1, m0 back to back.
        do_reset();
        for (int i = 0; i < 3; i++) preload(16'h0700 + 16'(i), 32'h7700_0000 + i);
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0 || c == 2) begin r0 = 1; a0 = 16'h0700 + 16'(c); end
            if (c == 1) begin r1 = 1; a1 = 16'h0701; end
            @(negedge clk);
            chk($sformatf("t6_v0_c%0d", c), v0[2], (c == 2) || (c == 4));
            chk($sformatf("t6_v1_c%0d", c), v1[2], c == 3);
            x = 32'h7700_0000 + 32'(c - 2);
            if (v0[2]) chk($sformatf("t6_d0_c%0d", c), d0[2], x);
            if (v1[2]) chk($sformatf("t6_d1_c%0d", c), d1[2], x);
            next_cycle();
        end
        idle();

        // Randomised traffic on all three builds against the reference.
        do_reset();
        for (int a = 0; a < 64; a++) begin
            x = $urandom;
            preload(16'(a), x);
            for (int k = 0; k < 3; k++) mm3[k][a] = x;
        end
        for (int k = 0; k < 3; k++) begin last_w[k] = 1; eq[k].delete(); end
        cyc = 0;
        new_req(0); new_req(1);
        for (int n = 0; n < 400; n++) begin
            if (n >= 396) idle();
            @(negedge clk);
            for (int k = 0; k < 3; k++) model_cycle(k);
            g0 = ~w0[0]; g1 = ~w1[0];
            next_cycle();
            cyc++;
            if (n < 395) begin
                if (g0) new_req(0);
                if (g1) new_req(1);
            end else begin
                idle();
            end
        end
        for (int k = 0; k < 3; k++) chk($sformatf("rnd%0d_drained", k), eq[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter for the single-port 64K x 32 on-chip RAM. The RAM's address is registered and its output is not.
- Master 0 is the Nios II data port; master 1 is the waveform-generator sample fetch engine.
- Issues at most one RAM access per clock and tracks in-flight reads in a tag pipeline, so each read's data is returned to the correct master with readdatavalid.

Parameters:
- ADDR_W, 16, word address width on both masters and on the RAM.
- DATA_W, 32, data width; BE_W = DATA_W/8 is derived, not overridable.
- READ_LATENCY, 1, cycles from RAM address-issue edge to valid mem_readdata; legal range 1..3.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = master 0 always wins.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same set and directions as m0_*, for master 1.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  BE_W  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  from RAM readdata.

Behaviour:
- Request: reqN = mN_read | mN_write. If both read and write are high on one master, it is treated as a write and no readdatavalid is produced.
- Grant is combinational in the same cycle. Exactly one of gnt0/gnt1 is high when any request is present.
- mN_waitrequest = reqN & ~gntN. It is also high while reset_n is low. A master holds its signals until waitrequest is low.
- RAM outputs are combinational muxes of the granted master's signals: mem_chipselect = gnt0|gnt1; mem_write = granted master's write.
- With no grant, mem_chipselect = 0, mem_write = 0, and address/byteenable/writedata are 0.
- mem_clken is tied to 1.
- Round-robin:
  - A 1-bit register last_gnt resets to 1, so master 0 wins the first conflict.
  - On a conflict, grant the master != last_gnt.
  - A lone requester is always granted immediately.
  - last_gnt updates only on cycles with a grant.
  - Under continuous contention, grants alternate 0,1,0,1…
- FIXED_PRIO = 1: master 0 wins every conflict and last_gnt is ignored.
- Read tag pipeline: READ_LATENCY stages of {valid, master_id}.
  - Stage 0 loads {gnt & read & ~write, granted id} every cycle.
  - The final stage drives mN_readdatavalid = valid & (id == N).
- mN_readdata = mem_readdata, passed through combinationally. It is don't-care when readdatavalid is low; the bench checks it only when valid.
- Throughput: one access per cycle. Back-to-back reads from either master are fully pipelined.
- Read data returns in issue order: a read granted at edge k is valid in the cycle after edge k+READ_LATENCY-1 completes, i.e. READ_LATENCY cycles after the grant cycle.
- Write completes in the grant cycle (no response phase).
- Reset (reset_n low at a clk edge):
  - Tag pipeline clears and last_gnt = 1.
  - All readdatavalid outputs are 0 from the next cycle.
  - In-flight reads are discarded and never reported.
  - Both waitrequests stay high while reset_n is low.
- Outputs after reset with no requests: waitrequest 0/0, readdatavalid 0/0, mem_chipselect 0, mem_write 0, mem_clken 1.

Decomposition:
- Package onchip_mem_pkg holds: MASTER_M0/MASTER_M1 id constants, the tag struct {valid, id}, and READ_LATENCY bounds checks.
- Natural sub-module: rr_arbiter2 (2-way round-robin with FIXED_PRIO option; inputs req[1:0], advance; output gnt[1:0]).
- The tag shift register stays inline.

Test Plan:
- Reset, then m0 read @0x0010 alone, with RAM preloaded 0xDEADBEEF → m0_waitrequest 0; m0_readdatavalid=1 exactly 1 cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 8 cycles (addresses 0x0100+i / 0x0200+i) → grants alternate starting with m0; each master receives 4 valids in address order; waitrequest high on alternate cycles.
- m1 write 0xA5A5A5A5, byteenable 4'b0011 @0x0300, then m0 read @0x0300 → m0 receives 0xXXXXA5A5 with the upper bytes unchanged from the preload (0x12345678 → 0x1234A5A5).
- FIXED_PRIO=1, both masters request for 5 cycles → m0 granted all 5; m1 waitrequest held high; m1 granted on the 6th cycle once m0 drops.
- m0 read issued, reset_n pulled low on the next edge → no readdatavalid on either master; both waitrequests high during reset; after release, the first conflict is granted to m0.
- READ_LATENCY=2 build with back-to-back reads m0,m1,m0 → valids appear on cycles +2,+3,+4 to the correct masters with the correct data.
